fifo_protocol_monitor: RTL and testbench

FIFO_PROTOCOL_MONITOR -- requirements
Module: fifo_protocol_monitor

---
 rtl/fifo_protocol_monitor_if.sv | 48 ++++
 rtl/fifo_protocol_monitor.sv | 177 +++++++++++++++++
 tb/tb_fifo_protocol_monitor.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_protocol_monitor_if.sv
// -----------------------------------------------------------------------------
// fifo_protocol_monitor_if
//   Bundles the signals exchanged between a multi-channel FIFO environment and
//   fifo_protocol_monitor.
//
//   Parameters : NCH   - number of monitored FIFO channels (1..32)
//                DEPTH - FIFO depth per channel (2..1024)
//                CNT_W - violation counter width
//   master     : drives enable, err_clr, push, pop, fifofull, fifoempty;
//                observes the monitor results.
//   slave      : the monitor itself; samples the FIFO signals, drives err_vec,
//                err_any, viol_count, first_valid, first_ch, first_code, occ.
// -----------------------------------------------------------------------------
interface fifo_protocol_monitor_if #(
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  // FIFO side
  logic                   enable;
  logic                   err_clr;
  logic [NCH-1:0]         push;
  logic [NCH-1:0]         pop;
  logic [NCH-1:0]         fifofull;
  logic [NCH-1:0]         fifoempty;

  // Monitor results
  logic [NCH-1:0]         err_vec;
  logic                   err_any;
  logic [CNT_W-1:0]       viol_count;
  logic                   first_valid;
  logic [CH_W-1:0]        first_ch;
  logic [2:0]             first_code;
  logic [NCH*OCC_W-1:0]   occ;

  modport master (
    output enable, err_clr, push, pop, fifofull, fifoempty,
    input  err_vec, err_any, viol_count, first_valid, first_ch, first_code, occ
  );

  modport slave (
    input  enable, err_clr, push, pop, fifofull, fifoempty,
    output err_vec, err_any, viol_count, first_valid, first_ch, first_code, occ
  );
endinterface

// File: rtl/fifo_protocol_monitor.sv
// -----------------------------------------------------------------------------
// fifo_protocol_monitor
//   Watches NCH FIFO channels for protocol violations. Each channel keeps a
//   shadow occupancy built from accepted pushes/pops; the FIFO's own full and
//   empty flags are checked against it, and pushes into a full FIFO or pops
//   from an empty FIFO are flagged. Errors are sticky per channel, counted in
//   a saturating counter, and the first error (lowest channel wins on a tie)
//   is recorded with its full set of error types.
//
//   Ports:
//     clk      - sole clock, rising edge
//     reset_n  - asynchronous active-low reset
//     mon      - fifo_protocol_monitor_if.slave bundle:
//                in : enable, err_clr, push, pop, fifofull, fifoempty
//                out: err_vec, err_any, viol_count, first_valid, first_ch,
//                     first_code (bit0 overflow, bit1 underflow, bit2 flag
//                     mismatch), occ (channel i at [i*OCC_W +: OCC_W])
//   All outputs are registered: an error seen in cycle N shows up in N+1.
// -----------------------------------------------------------------------------
module fifo_protocol_monitor #(
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fifo_protocol_monitor_if.slave mon
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  // Wide enough to hold CNT_MAX plus up to 32 simultaneous channel errors.
  localparam int SUM_W = CNT_W + 6;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Per-channel checks and shadow occupancy
  // ---------------------------------------------------------------------------
  logic [OCC_W-1:0] occ_q [NCH];
  logic [OCC_W-1:0] occ_d [NCH];

  logic [NCH-1:0] ovf;        // push into a full FIFO without a matching pop
  logic [NCH-1:0] udf;        // pop from an empty FIFO
  logic [NCH-1:0] mis;        // FIFO flags disagree with shadow occupancy
  logic [NCH-1:0] err_now;    // channel in error this cycle (enable applied)
  logic [NCH-1:0] acc_push;
  logic [NCH-1:0] acc_pop;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    ovf      = '0;
    udf      = '0;
    mis      = '0;
    err_now  = '0;
    acc_push = '0;
    acc_pop  = '0;
    for (int i = 0; i < NCH; i++) begin
      occ_d[i] = occ_q[i];

      ovf[i] = mon.push[i] & ~mon.pop[i] & mon.fifofull[i];
      udf[i] = mon.pop[i] & mon.fifoempty[i];
      mis[i] = (mon.fifofull[i]  != (occ_q[i] == OCC_FULL)) |
               (mon.fifoempty[i] != (occ_q[i] == '0));
      err_now[i] = mon.enable & (ovf[i] | udf[i] | mis[i]);

      // A pop alongside a push to a full FIFO frees the slot, so the push
      // still goes in; a push to an empty FIFO still lands even when the
      // simultaneous pop underflows.
      acc_push[i] = mon.push[i] & ~(mon.fifofull[i] & ~mon.pop[i]);
      acc_pop[i]  = mon.pop[i] & ~mon.fifoempty[i];

      // Flags can lie, so the shadow count is clamped to 0..DEPTH.
      unique case ({acc_push[i], acc_pop[i]})
        2'b10:   occ_d[i] = (occ_q[i] >= OCC_FULL) ? OCC_FULL
                                                   : occ_q[i] + OCC_W'(1);
        2'b01:   occ_d[i] = (occ_q[i] == '0) ? '0 : occ_q[i] - OCC_W'(1);
        default: occ_d[i] = occ_q[i];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error bookkeeping
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   err_vec_q,     err_vec_d;
  logic             err_any_q,     err_any_d;
  logic [CNT_W-1:0] viol_count_q,  viol_count_d;
  logic             first_valid_q, first_valid_d;
  logic [CH_W-1:0]  first_ch_q,    first_ch_d;
  logic [2:0]       first_code_q,  first_code_d;

  logic [5:0]       n_err;
  logic [SUM_W-1:0] cnt_sum;
  logic [CH_W-1:0]  low_ch;
  logic [2:0]       low_code;

  always_comb begin
    n_err    = '0;
    low_ch   = '0;
    low_code = '0;
    // Scanning downward lets the lowest erroring channel be the last writer.
    for (int i = NCH - 1; i >= 0; i--) begin
      n_err = n_err + 6'(err_now[i]);
      if (err_now[i]) begin
        low_ch   = CH_W'(i);
        low_code = {mis[i], udf[i], ovf[i]};
      end
    end

    // err_clr empties the state first; this cycle's errors are then applied
    // on top, so an error coincident with a clear is kept.
    err_vec_d     = mon.err_clr ? '0   : err_vec_q;
    viol_count_d  = mon.err_clr ? '0   : viol_count_q;
    first_valid_d = mon.err_clr ? 1'b0 : first_valid_q;
    first_ch_d    = mon.err_clr ? '0   : first_ch_q;
    first_code_d  = mon.err_clr ? '0   : first_code_q;

    err_vec_d = err_vec_d | err_now;

    cnt_sum      = SUM_W'(viol_count_d) + SUM_W'(n_err);
    viol_count_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    if (!first_valid_d && (|err_now)) begin
      first_valid_d = 1'b1;
      first_ch_d    = low_ch;
      first_code_d  = low_code;
    end

    err_any_d = |err_vec_d;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the occupancy array is ordinary flop state that must read 0
      // straight out of reset, so it is reset like any other register rather
      // than treated as a RAM.
      for (int i = 0; i < NCH; i++) occ_q[i] <= '0;
      err_vec_q     <= '0;
      err_any_q     <= 1'b0;
      viol_count_q  <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_code_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < NCH; i++) occ_q[i] <= occ_d[i];
      err_vec_q     <= err_vec_d;
      err_any_q     <= err_any_d;
      viol_count_q  <= viol_count_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
      first_code_q  <= first_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (straight from registers)
  // ---------------------------------------------------------------------------
  assign mon.err_vec     = err_vec_q;
  assign mon.err_any     = err_any_q;
  assign mon.viol_count  = viol_count_q;
  assign mon.first_valid = first_valid_q;
  assign mon.first_ch    = first_ch_q;
  assign mon.first_code  = first_code_q;

  for (genvar g = 0; g < NCH; g++) begin : g_occ
    assign mon.occ[g*OCC_W +: OCC_W] = occ_q[g];
  end

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// -----------------------------------------------------------------------------
// tb_fifo_protocol_monitor
//   Two monitors (CNT_W=16 and CNT_W=2) see identical stimulus. A directed
//   table walks through fill/overflow/underflow/clear/mismatch/disable cases,
//   hand sequences cover counter saturation, clear-vs-error and asynchronous
//   reset, then random traffic is compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_fifo_protocol_monitor;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_A = 16;
  localparam int CNT_B = 2;
  localparam int OCC_W = 3;
  localparam int MAX_A = (1 << CNT_A) - 1;
  localparam int MAX_B = (1 << CNT_B) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fifo_protocol_monitor_if #(.NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_A)) bus_a ();
  fifo_protocol_monitor_if #(.NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_B)) bus_b ();

  fifo_protocol_monitor #(.NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .mon(bus_a)
  );
  fifo_protocol_monitor #(.NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .mon(bus_b)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic           s_en, s_clr;
  logic [NCH-1:0] s_push, s_pop, s_full, s_empty;

  task automatic set_in(input logic en, input logic clr,
                        input logic [NCH-1:0] pu, input logic [NCH-1:0] po,
                        input logic [NCH-1:0] fu, input logic [NCH-1:0] em);
    s_en = en; s_clr = clr; s_push = pu; s_pop = po; s_full = fu; s_empty = em;
    bus_a.enable = en; bus_a.err_clr = clr; bus_a.push = pu; bus_a.pop = po;
    bus_a.fifofull = fu; bus_a.fifoempty = em;
    bus_b.enable = en; bus_b.err_clr = clr; bus_b.push = pu; bus_b.pop = po;
    bus_b.fifofull = fu; bus_b.fifoempty = em;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference: integer occupancy per channel, a list of erroring
  // channels per cycle, plain integer counters capped by min().
  // ---------------------------------------------------------------------------
  int             m_occ [NCH];
  logic [NCH-1:0] m_err;
  int             m_cnt_a, m_cnt_b;
  logic           m_fv;
  int             m_fch;
  logic [2:0]     m_fcode;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_occ[c] = 0;
    m_err = '0; m_cnt_a = 0; m_cnt_b = 0; m_fv = 1'b0; m_fch = 0; m_fcode = '0;
  endtask

  task automatic model_step();
    int         bad[$];
    logic [2:0] kind [NCH];
    for (int c = 0; c < NCH; c++) begin
      bit o, u, m;
      int ap, ad;
      o = s_push[c] && !s_pop[c] && s_full[c];
      u = s_pop[c] && s_empty[c];
      m = (s_full[c] != (m_occ[c] == DEPTH)) || (s_empty[c] != (m_occ[c] == 0));
      kind[c] = {m, u, o};
      if (s_en && (o || u || m)) bad.push_back(c);
      ap = (s_push[c] && !(s_full[c] && !s_pop[c])) ? 1 : 0;
      ad = (s_pop[c] && !s_empty[c]) ? 1 : 0;
      m_occ[c] = m_occ[c] + ap - ad;
      if (m_occ[c] < 0)     m_occ[c] = 0;
      if (m_occ[c] > DEPTH) m_occ[c] = DEPTH;
    end
    if (s_clr) begin
      m_err = '0; m_cnt_a = 0; m_cnt_b = 0; m_fv = 1'b0; m_fch = 0; m_fcode = '0;
    end
    foreach (bad[k]) m_err[bad[k]] = 1'b1;
    m_cnt_a = (m_cnt_a + bad.size() > MAX_A) ? MAX_A : m_cnt_a + bad.size();
    m_cnt_b = (m_cnt_b + bad.size() > MAX_B) ? MAX_B : m_cnt_b + bad.size();
    if (!m_fv && bad.size() > 0) begin
      m_fv    = 1'b1;
      m_fch   = bad[0];          // pushed in ascending channel order
      m_fcode = kind[bad[0]];
    end
  endtask

  function automatic logic [NCH*OCC_W-1:0] model_occ();
    logic [NCH*OCC_W-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c*OCC_W +: OCC_W] = OCC_W'(m_occ[c]);
    return v;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".err_vec"},     64'(bus_a.err_vec),     64'(m_err));
    check({tag, ".err_any"},     64'(bus_a.err_any),     64'(|m_err));
    check({tag, ".viol_a"},      64'(bus_a.viol_count),  64'(m_cnt_a));
    check({tag, ".viol_b"},      64'(bus_b.viol_count),  64'(m_cnt_b));
    check({tag, ".first_valid"}, 64'(bus_a.first_valid), 64'(m_fv));
    check({tag, ".first_ch"},    64'(bus_a.first_ch),    64'(m_fch));
    check({tag, ".first_code"},  64'(bus_a.first_code),  64'(m_fcode));
    check({tag, ".occ"},         64'(bus_a.occ),         64'(model_occ()));
  endtask

  // One clock: model consumes the inputs, DUT sees the edge, sample #1 later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".err_vec"},     64'(bus_a.err_vec),     64'd0);
    check({tag, ".err_any"},     64'(bus_a.err_any),     64'd0);
    check({tag, ".viol_a"},      64'(bus_a.viol_count),  64'd0);
    check({tag, ".viol_b"},      64'(bus_b.viol_count),  64'd0);
    check({tag, ".first_valid"}, 64'(bus_a.first_valid), 64'd0);
    check({tag, ".first_ch"},    64'(bus_a.first_ch),    64'd0);
    check({tag, ".first_code"},  64'(bus_a.first_code),  64'd0);
    check({tag, ".occ"},         64'(bus_a.occ),         64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       en, clr;
    logic [3:0] push, pop, full, empty;
    logic [3:0] e_vec;
    int         e_cnt;
    logic       e_fv;
    int         e_ch;
    logic [2:0] e_code;
    logic [11:0] e_occ;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic clr,
                              input logic [3:0] pu, input logic [3:0] po,
                              input logic [3:0] fu, input logic [3:0] em,
                              input logic [3:0] ev, input int cnt,
                              input logic fv, input int ch,
                              input logic [2:0] code, input logic [11:0] oc);
    vec_t v;
    v.en = en; v.clr = clr; v.push = pu; v.pop = po; v.full = fu; v.empty = em;
    v.e_vec = ev; v.e_cnt = cnt; v.e_fv = fv; v.e_ch = ch; v.e_code = code;
    v.e_occ = oc;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    // Fill ch2 to full with honest flags.
    tbl[0]  = mk(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 3'b000, 12'h040);
    tbl[1]  = mk(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h080);
    tbl[2]  = mk(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h0C0);
    tbl[3]  = mk(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h100);
    // Push into full ch2 -> overflow.
    tbl[4]  = mk(1, 0, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 4'b0100, 1, 1, 2, 3'b001, 12'h100);
    // Clear + simultaneous underflow on ch0 and ch3 -> error wins, ch0 first.
    tbl[5]  = mk(1, 1, 4'b0000, 4'b1001, 4'b0100, 4'b1011, 4'b1001, 2, 1, 0, 3'b010, 12'h100);
    // ch1 overflow (full with occ=0, also a mismatch); first record holds.
    tbl[6]  = mk(1, 0, 4'b0010, 4'b0000, 4'b0110, 4'b1011, 4'b1011, 3, 1, 0, 3'b010, 12'h100);
    // Clear; pop ch2 twice down to 2.
    tbl[7]  = mk(1, 1, 4'b0000, 4'b0100, 4'b0100, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h0C0);
    tbl[8]  = mk(1, 0, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h080);
    // Full flag raised with occ=2 -> flag mismatch only.
    tbl[9]  = mk(1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 4'b0100, 1, 1, 2, 3'b100, 12'h080);
    tbl[10] = mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h080);
    // Disabled: same bogus flags, no flags recorded, occ keeps tracking.
    tbl[11] = mk(0, 0, 4'b0000, 4'b0100, 4'b0100, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h040);
    tbl[12] = mk(0, 0, 4'b0101, 4'b0000, 4'b0100, 4'b1011, 4'b0000, 0, 0, 0, 3'b000, 12'h041);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    set_in(1'b1, 1'b0, '0, '0, '0, '1);
    model_reset();
    reset_n = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    compare_model("idle");

    // Directed table
    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      set_in(tbl[i].en, tbl[i].clr, tbl[i].push, tbl[i].pop, tbl[i].full, tbl[i].empty);
      model_step();
      @(posedge clk);
      #1;
      check({tag, ".err_vec"},     64'(bus_a.err_vec),     64'(tbl[i].e_vec));
      check({tag, ".err_any"},     64'(bus_a.err_any),     64'(|tbl[i].e_vec));
      check({tag, ".viol_a"},      64'(bus_a.viol_count),  64'(tbl[i].e_cnt));
      check({tag, ".viol_b"},      64'(bus_b.viol_count),
            64'((tbl[i].e_cnt > MAX_B) ? MAX_B : tbl[i].e_cnt));
      check({tag, ".first_valid"}, 64'(bus_a.first_valid), 64'(tbl[i].e_fv));
      check({tag, ".first_ch"},    64'(bus_a.first_ch),    64'(tbl[i].e_ch));
      check({tag, ".first_code"},  64'(bus_a.first_code),  64'(tbl[i].e_code));
      check({tag, ".occ"},         64'(bus_a.occ),         64'(tbl[i].e_occ));
    end

    // Counter saturation on the 2-bit instance: five overflow cycles on ch0.
    set_in(1'b1, 1'b0, '0, '0, '0, '1);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b1111);
      cycle($sformatf("sat%0d", i));
    end
    check("sat.viol_b_held", 64'(bus_b.viol_count), 64'd3);
    check("sat.viol_a",      64'(bus_a.viol_count), 64'd5);
    // Clear with the same error still present; also push ch1 so occ is nonzero.
    set_in(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b1111);
    cycle("clr_err");
    check("clr_err.viol_b",      64'(bus_b.viol_count),  64'd1);
    check("clr_err.first_valid", 64'(bus_a.first_valid), 64'd1);
    check("clr_err.first_code",  64'(bus_a.first_code),  64'd5);

    // Asynchronous reset between edges with errors pending.
    set_in(1'b1, 1'b0, '0, '0, '0, '1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    compare_model("post_rst");

    // Random traffic: mostly honest flags from the model, occasional lies.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] pu, po, fu, em;
      for (int c = 0; c < NCH; c++) begin
        pu[c] = ($urandom_range(0, 99) < 55);
        po[c] = ($urandom_range(0, 99) < 40);
        fu[c] = (m_occ[c] == DEPTH) ^ ($urandom_range(0, 99) < 4);
        em[c] = (m_occ[c] == 0)     ^ ($urandom_range(0, 99) < 4);
      end
      set_in($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 4, pu, po, fu, em);
      cycle($sformatf("rnd%0d", i));
      if (i == 200) begin
        // Mid-run reset: everything restarts from zero occupancy.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rnd_rst.occ",     64'(bus_a.occ),     64'd0);
        check("rnd_rst.err_vec", 64'(bus_a.err_vec), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
